// File: rtl/gb_pkg.sv
// Shared helpers for the streaming Gaussian-blur engine: binomial weights,
// derived accumulator widths and parameter legality.
package gb_pkg;

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Weight total is 4^(K-1), so 2(K-1) extra bits hold the full sum.
  function automatic int sum_w(input int pix_w, input int k);
    return pix_w + 2 * (k - 1);
  endfunction

  function automatic int shift_of(input int k);
    return 2 * (k - 1);
  endfunction

  function automatic int round_of(input int k);
    return 1 << (2 * k - 3);
  endfunction

  function automatic bit params_ok(input int k, input int img_w, input int img_h);
    return (k >= 3) && (k <= 9) && (k % 2 == 1) && (img_w >= k) && (img_h >= k);
  endfunction

endpackage

// File: rtl/gb_binomial_kernel.sv
// Combinational KxK binomial-Gaussian weighted sum with round-half-up.
module gb_binomial_kernel
  import gb_pkg::*;
#(
  parameter int K     = 3,
  parameter int PIX_W = 8
) (
  input  logic [K-1:0][K-1:0][PIX_W-1:0] win_i,
  output logic [PIX_W-1:0]               pix_o
);

  localparam int SUM_W = sum_w(PIX_W, K);
  localparam int SHIFT = shift_of(K);
  localparam int ROUND = round_of(K);

  logic [SUM_W-1:0] acc;

  // Rounding bias is folded into the accumulator seed.
  always_comb begin
    acc = SUM_W'(ROUND);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc = acc + SUM_W'(win_i[r][c]) * SUM_W'(binom(K - 1, r) * binom(K - 1, c));
  end

  assign pix_o = PIX_W'(acc >> SHIFT);

endmodule

// File: rtl/gb_stencil_stream.sv
// Streaming KxK Gaussian blur: K-1 line buffers, sliding window, one
// registered output stage with TLAST and a frame-done pulse.
module gb_stencil_stream
  import gb_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 488,
  parameter int IMG_H = 648,
  parameter int K     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PIX_W-1:0]          arg_1_TDATA,
  input  logic                      arg_1_TVALID,
  output logic                      arg_1_TREADY,
  output logic [PIX_W-1:0]          arg_0_TDATA,
  output logic                      arg_0_TVALID,
  input  logic                      arg_0_TREADY,
  output logic                      arg_0_TLAST,
  output logic                      frame_done,
  output logic [$clog2(IMG_W)-1:0]  cur_x,
  output logic [$clog2(IMG_H)-1:0]  cur_y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  if (!params_ok(K, IMG_W, IMG_H)) begin : g_bad_params
    $error("gb_stencil_stream: K must be odd in 3..9 and IMG_W, IMG_H >= K");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          accept, x_end, y_end, emit;

  logic [PIX_W-1:0]               lb_q [K-1][IMG_W];
  logic [K-1:0][PIX_W-1:0]        col;
  logic [K-1:0][K-1:0][PIX_W-1:0] win_q, win_d;
  logic [PIX_W-1:0]               filt;

  logic             tvalid_q, tlast_q, fdone_q;
  logic [PIX_W-1:0] tdata_q;

  assign arg_1_TREADY = !tvalid_q || arg_0_TREADY;
  assign accept       = arg_1_TVALID && arg_1_TREADY;
  assign x_end        = (x_q == XW'(IMG_W - 1));
  assign y_end        = (y_q == YW'(IMG_H - 1));
  assign emit         = (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Row 0 of the column is the oldest buffered row; the live pixel is row K-1.
  always_comb begin
    col = '0;
    for (int r = 0; r < K - 1; r++) col[r] = lb_q[K-2-r][x_q];
    col[K-1] = arg_1_TDATA;
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = col[r];
    end
  end

  gb_binomial_kernel #(.K(K), .PIX_W(PIX_W)) u_kernel (
    .win_i (win_d),
    .pix_o (filt)
  );

  // Line-buffer RAM carries no reset; stale rows are overwritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][x_q] <= arg_1_TDATA;
      for (int i = 1; i < K - 1; i++) lb_q[i][x_q] <= lb_q[i-1][x_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      fdone_q <= accept && x_end && y_end;
      if (accept) win_q <= win_d;
      if (accept && emit) begin
        tvalid_q <= 1'b1;
        tdata_q  <= filt;
        tlast_q  <= x_end && y_end;
      end else if (arg_0_TREADY) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  assign arg_0_TVALID = tvalid_q;
  assign arg_0_TDATA  = tdata_q;
  assign arg_0_TLAST  = tlast_q;
  assign frame_done   = fdone_q;
  assign cur_x        = x_q;
  assign cur_y        = y_q;

endmodule

// File: tb/tb_gb_stencil_stream.sv
// Scoreboard bench: stimulus pushes expected outputs, monitors pop on handshake.
module tb_gb_stencil_stream;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  // 8x6, K=3 instance
  logic [7:0] i_data = 0, o_data;
  logic i_valid = 0, i_ready, o_valid, o_ready = 1, o_last, fdone;
  logic [2:0] cx, cy;

  // 9x9, K=5 instance
  logic [7:0] i5_data = 0, o5_data;
  logic i5_valid = 0, i5_ready, o5_valid, o5_ready = 1, o5_last, fdone5;
  logic [3:0] cx5, cy5;

  gb_stencil_stream #(.PIX_W(8), .IMG_W(8), .IMG_H(6), .K(3)) dut (
    .clk(clk), .rst(rst),
    .arg_1_TDATA(i_data), .arg_1_TVALID(i_valid), .arg_1_TREADY(i_ready),
    .arg_0_TDATA(o_data), .arg_0_TVALID(o_valid), .arg_0_TREADY(o_ready),
    .arg_0_TLAST(o_last), .frame_done(fdone), .cur_x(cx), .cur_y(cy)
  );

  gb_stencil_stream #(.PIX_W(8), .IMG_W(9), .IMG_H(9), .K(5)) dut5 (
    .clk(clk), .rst(rst),
    .arg_1_TDATA(i5_data), .arg_1_TVALID(i5_valid), .arg_1_TREADY(i5_ready),
    .arg_0_TDATA(o5_data), .arg_0_TVALID(o5_valid), .arg_0_TREADY(o5_ready),
    .arg_0_TLAST(o5_last), .frame_done(fdone5), .cur_x(cx5), .cur_y(cy5)
  );

  int n_chk = 0, n_fail = 0;
  int out3 = 0, out5 = 0, fd_cnt = 0, fd5_cnt = 0;
  exp_t q3[$], q5[$];
  exp_t e3, e5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fdone)  fd_cnt++;
    if (fdone5) fd5_cnt++;
  end

  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) begin
      out3++;
      if (q3.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut3 unexpected output: got %0d expected none", o_data);
      end else begin
        e3 = q3.pop_front();
        chk("dut3 data", o_data, e3.d);
        chk("dut3 last", o_last, e3.l);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o5_valid && o5_ready) begin
      out5++;
      if (q5.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut5 unexpected output: got %0d expected none", o5_data);
      end else begin
        e5 = q5.pop_front();
        chk("dut5 data", o5_data, e5.d);
        chk("dut5 last", o5_last, e5.l);
      end
    end
  end

  // kind 0: constant c; kind 1: 255 impulse at (3,3); kind 2: ramp x+8y
  function automatic logic [7:0] pix_of(input int kind, input int c, input int x, input int y);
    if (kind == 0) return 8'(c);
    if (kind == 1) return (x == 3 && y == 3) ? 8'd255 : 8'd0;
    return 8'(x + 8 * y);
  endfunction

  // Expected output for the window whose bottom-right pixel is (x,y).
  function automatic logic [7:0] exp_of(input int kind, input int c, input int x, input int y);
    int b[3];
    int dr, dc, w;
    b = '{1, 2, 1};
    if (kind == 0) return 8'(c);
    if (kind == 2) return 8'((x - 1) + 8 * (y - 1));
    dc = 3 - (x - 2);
    dr = 3 - (y - 2);
    w = (dc >= 0 && dc <= 2 && dr >= 0 && dr <= 2) ? b[dr] * b[dc] : 0;
    return 8'((255 * w + 8) >> 4);
  endfunction

  task automatic send3(input logic [7:0] p);
    bit acc;
    int g;
    g = 0;
    i_valid = 1; i_data = p;
    do begin
      @(negedge clk); acc = i_ready;
      @(posedge clk); #1; g++;
    end while (!acc && g < 200);
    if (!acc) chk("send3 timeout", 0, 1);
    i_valid = 0;
  endtask

  task automatic send5(input logic [7:0] p);
    bit acc;
    int g;
    g = 0;
    i5_valid = 1; i5_data = p;
    do begin
      @(negedge clk); acc = i5_ready;
      @(posedge clk); #1; g++;
    end while (!acc && g < 200);
    if (!acc) chk("send5 timeout", 0, 1);
    i5_valid = 0;
  endtask

  task automatic drain3();
    int g;
    g = 0;
    while (q3.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
    chk("dut3 scoreboard drained", q3.size(), 0);
    q3.delete();
  endtask

  // Output for (2,2) of the ramp is pending; hold TREADY low with pixel (3,2) offered.
  task automatic stall5();
    o_ready = 0; i_valid = 1; i_data = pix_of(2, 0, 3, 2);
    repeat (5) begin
      @(negedge clk);
      chk("stall tvalid", o_valid, 1);
      chk("stall tdata", o_data, 9);
      chk("stall tlast", o_last, 0);
      chk("stall in ready", i_ready, 0);
      @(posedge clk); #1;
    end
    chk("stall cur_x held", cx, 3);
    i_valid = 0; o_ready = 1;
  endtask

  task automatic run3(input int kind, input int c, input bit stall);
    int fd0, oc0;
    fd0 = fd_cnt; oc0 = out3;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        if (x >= 2 && y >= 2) q3.push_back({exp_of(kind, c, x, y), (x == 7 && y == 5)});
        send3(pix_of(kind, c, x, y));
        if (x == 7 && y == 5) chk("frame_done after last pixel", fdone, 1);
        if (stall && x == 2 && y == 2) stall5();
      end
    drain3();
    chk("dut3 outputs per frame", out3 - oc0, 24);
    chk("dut3 frame_done count", fd_cnt - fd0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset tvalid", o_valid, 0);
    chk("reset tdata", o_data, 0);
    chk("reset tlast", o_last, 0);
    chk("reset frame_done", fdone, 0);
    chk("reset cur_x", cx, 0);
    chk("reset cur_y", cy, 0);
    rst = 0;

    run3(0, 100, 0);
    run3(1, 0, 0);
    run3(2, 0, 1);

    // partial frame then reset
    for (int i = 0; i < 20; i++) begin
      if (i % 8 >= 2 && i / 8 >= 2) q3.push_back({8'd77, 1'b0});
      send3(8'd77);
    end
    @(posedge clk); #1;
    chk("partial cur_x", cx, 4);
    chk("partial cur_y", cy, 2);
    chk("partial outputs drained", q3.size(), 0);
    rst = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("tvalid during reset", o_valid, 0);
    end
    rst = 0;
    chk("post-reset cur_x", cx, 0);
    chk("post-reset cur_y", cy, 0);
    run3(0, 50, 0);

    // back-to-back frames
    run3(2, 0, 0);
    run3(0, 0, 0);

    // K=5 at full scale
    begin
      int fd0, oc0, g;
      fd0 = fd5_cnt; oc0 = out5;
      for (int y = 0; y < 9; y++)
        for (int x = 0; x < 9; x++) begin
          if (x >= 4 && y >= 4) q5.push_back({8'd255, (x == 8 && y == 8)});
          send5(8'd255);
        end
      g = 0;
      while (q5.size() != 0 && g < 100) begin @(posedge clk); #1; g++; end
      chk("dut5 scoreboard drained", q5.size(), 0);
      chk("dut5 outputs per frame", out5 - oc0, 25);
      chk("dut5 frame_done count", fd5_cnt - fd0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
